// File: rtl/udp_rx_parser_if.sv
// Signal bundle between the receive buffer, the UDP parser and its payload consumer.
// master = parser side; slave = buffer/consumer environment side.
interface udp_rx_parser_if;
    logic [31:0] buf_data;
    logic        buf_data_av;
    logic        buf_rd_en;
    logic [15:0] hdr_src_port;
    logic [15:0] hdr_dst_port;
    logic [15:0] hdr_length;
    logic [15:0] hdr_checksum;
    logic        hdr_valid;
    logic        hdr_error;
    logic [31:0] pay_data;
    logic [3:0]  pay_keep;
    logic        pay_valid;
    logic        pay_last;
    logic        pay_ready;
    logic [15:0] csum;
    logic        csum_valid;

    modport master (
        input  buf_data, buf_data_av, pay_ready,
        output buf_rd_en, hdr_src_port, hdr_dst_port, hdr_length, hdr_checksum,
               hdr_valid, hdr_error, pay_data, pay_keep, pay_valid, pay_last,
               csum, csum_valid
    );

    modport slave (
        output buf_data, buf_data_av, pay_ready,
        input  buf_rd_en, hdr_src_port, hdr_dst_port, hdr_length, hdr_checksum,
               hdr_valid, hdr_error, pay_data, pay_keep, pay_valid, pay_last,
               csum, csum_valid
    );
endinterface

// File: rtl/udp_rx_parser.sv
// Pops words from the receive buffer, decodes the 8-byte UDP header, streams the
// payload with keep/last and accumulates the one's-complement sum of header + payload.
module udp_rx_parser #(
    parameter int HDR_WORDS = 2
) (
    input  logic         clk,
    input  logic         reset,
    udp_rx_parser_if.master bus
);

    localparam logic [1:0]  S_HDR0    = 2'd0;
    localparam logic [1:0]  S_HDR1    = 2'd1;
    localparam logic [1:0]  S_PAY     = 2'd2;
    localparam logic [15:0] HDR_BYTES = 16'(HDR_WORDS * 4);

    function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    function automatic logic [3:0] tail_keep(input logic [2:0] rem);
        case (rem)
            3'd1:    return 4'b1000;
            3'd2:    return 4'b1100;
            3'd3:    return 4'b1110;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] mask_bytes(input logic [31:0] w, input logic [3:0] keep);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = keep[i] ? w[8*i +: 8] : 8'h00;
        end
        return m;
    endfunction

    logic [1:0]  state_q, state_d;
    logic        inflight_q;
    logic [15:0] src_q, src_d, dst_q, dst_d, len_q, len_d, chk_q, chk_d;
    logic        hdr_valid_q, hdr_valid_d, hdr_error_q, hdr_error_d;
    logic [15:0] rem_q, rem_d;
    logic [31:0] pay_data_q, pay_data_d;
    logic [3:0]  pay_keep_q, pay_keep_d;
    logic        pay_valid_q, pay_valid_d, pay_last_q, pay_last_d;
    logic [15:0] acc_q, acc_d, csum_q, csum_d;
    logic        csum_valid_q, csum_valid_d;

    logic        wants_data, rd_en, pay_hs, last_word;
    logic [3:0]  word_keep;
    logic [31:0] word_masked;

    // A payload read is only issued while the output register is free or draining
    // a non-last word, so at most one word is ever waiting behind the register.
    assign wants_data  = (state_q != S_PAY) || (rem_q != 16'd0);
    assign rd_en       = bus.buf_data_av && !inflight_q && wants_data &&
                         ((state_q != S_PAY) || !pay_valid_q || (bus.pay_ready && !pay_last_q));
    assign pay_hs      = pay_valid_q && bus.pay_ready;
    assign last_word   = (rem_q <= 16'd4);
    assign word_keep   = last_word ? tail_keep(rem_q[2:0]) : 4'b1111;
    assign word_masked = mask_bytes(bus.buf_data, word_keep);

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        chk_d        = chk_q;
        hdr_valid_d  = 1'b0;
        hdr_error_d  = 1'b0;
        rem_d        = rem_q;
        pay_data_d   = pay_data_q;
        pay_keep_d   = pay_keep_q;
        pay_valid_d  = pay_valid_q;
        pay_last_d   = pay_last_q;
        acc_d        = acc_q;
        csum_d       = csum_q;
        csum_valid_d = 1'b0;

        if (pay_hs) pay_valid_d = 1'b0;

        case (state_q)
            S_HDR0: begin
                if (inflight_q) begin
                    src_d   = bus.buf_data[31:16];
                    dst_d   = bus.buf_data[15:0];
                    acc_d   = csum_add(bus.buf_data[31:16], bus.buf_data[15:0]);
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                if (inflight_q) begin
                    len_d       = bus.buf_data[31:16];
                    chk_d       = bus.buf_data[15:0];
                    acc_d       = csum_add(csum_add(acc_q, bus.buf_data[31:16]), bus.buf_data[15:0]);
                    hdr_valid_d = 1'b1;
                    if (bus.buf_data[31:16] < HDR_BYTES) begin
                        hdr_error_d = 1'b1;
                        state_d     = S_HDR0;
                    end else if (bus.buf_data[31:16] == HDR_BYTES) begin
                        csum_valid_d = 1'b1;
                        csum_d       = acc_d;
                        state_d      = S_HDR0;
                    end else begin
                        rem_d   = bus.buf_data[31:16] - HDR_BYTES;
                        state_d = S_PAY;
                    end
                end
            end
            S_PAY: begin
                if (inflight_q) begin
                    pay_data_d  = word_masked;
                    pay_keep_d  = word_keep;
                    pay_valid_d = 1'b1;
                    pay_last_d  = last_word;
                    rem_d       = last_word ? 16'd0 : rem_q - 16'd4;
                    acc_d       = csum_add(csum_add(acc_q, word_masked[31:16]), word_masked[15:0]);
                end
                if (pay_hs && pay_last_q) begin
                    pay_last_d   = 1'b0;
                    csum_valid_d = 1'b1;
                    csum_d       = acc_q;
                    state_d      = S_HDR0;
                end
            end
            default: state_d = S_HDR0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_HDR0;
            inflight_q   <= 1'b0;
            src_q        <= 16'd0;
            dst_q        <= 16'd0;
            len_q        <= 16'd0;
            chk_q        <= 16'd0;
            hdr_valid_q  <= 1'b0;
            hdr_error_q  <= 1'b0;
            rem_q        <= 16'd0;
            pay_data_q   <= 32'd0;
            pay_keep_q   <= 4'd0;
            pay_valid_q  <= 1'b0;
            pay_last_q   <= 1'b0;
            acc_q        <= 16'd0;
            csum_q       <= 16'd0;
            csum_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            inflight_q   <= rd_en;
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            chk_q        <= chk_d;
            hdr_valid_q  <= hdr_valid_d;
            hdr_error_q  <= hdr_error_d;
            rem_q        <= rem_d;
            pay_data_q   <= pay_data_d;
            pay_keep_q   <= pay_keep_d;
            pay_valid_q  <= pay_valid_d;
            pay_last_q   <= pay_last_d;
            acc_q        <= acc_d;
            csum_q       <= csum_d;
            csum_valid_q <= csum_valid_d;
        end
    end

    assign bus.buf_rd_en    = rd_en;
    assign bus.hdr_src_port = src_q;
    assign bus.hdr_dst_port = dst_q;
    assign bus.hdr_length   = len_q;
    assign bus.hdr_checksum = chk_q;
    assign bus.hdr_valid    = hdr_valid_q;
    assign bus.hdr_error    = hdr_error_q;
    assign bus.pay_data     = pay_data_q;
    assign bus.pay_keep     = pay_keep_q;
    assign bus.pay_valid    = pay_valid_q;
    assign bus.pay_last     = pay_last_q;
    assign bus.csum         = csum_q;
    assign bus.csum_valid   = csum_valid_q;

endmodule
